// File: rtl/acc_data_veri_rx_if.sv
// Host-side word channel and accelerator-side entry channel of acc_data_veri_rx.
// master: the host/accelerator environment; slave: the receiver block.
interface acc_data_veri_rx_if #(
    parameter int unsigned CNT_W = 4
);
    logic             wr_req;
    logic [31:0]      host_data;
    logic             wr_ack;
    logic             rx_ready;
    logic             rx_overflow;
    logic             ovf_clr;
    logic             veri_ins_pop;
    logic [127:0]     veri_data_out;
    logic             veri_data_out_vld;
    logic [CNT_W-1:0] fifo_count;
    logic             frame_busy;

    modport master (
        output wr_req, host_data, ovf_clr, veri_ins_pop,
        input  wr_ack, rx_ready, rx_overflow, veri_data_out, veri_data_out_vld,
               fifo_count, frame_busy
    );

    modport slave (
        input  wr_req, host_data, ovf_clr, veri_ins_pop,
        output wr_ack, rx_ready, rx_overflow, veri_data_out, veri_data_out_vld,
               fifo_count, frame_busy
    );
endinterface

// File: rtl/acc_data_veri_rx.sv
// Host word receiver: packs four 32-bit host words (first word in the low
// bits) into 128-bit entries, buffers them in a FIFO and hands them to the
// accelerator one per pop request.
module acc_data_veri_rx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input logic               clk_100M,
    input logic               rst,
    acc_data_veri_rx_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic             wr_req_d;
    logic [1:0]       word_cnt;
    // Upper 96 bits of the assembly shift register; the lowest word would be
    // shifted out by the fourth accept, so it is never kept.
    logic [95:0]      asm_reg;
    logic [127:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_ack;
    logic             rx_overflow;
    logic [127:0]     data_out;
    logic             data_out_vld;

    logic             wr_pulse;
    logic             rx_ready;
    logic             accept;
    logic             drop;
    logic             push;
    logic             pop;
    logic [127:0]     push_entry;

    // Handshake decode from registered state only.
    always_comb begin
        wr_pulse   = bus.wr_req & ~wr_req_d;
        rx_ready   = ~((word_cnt == 2'd3) && (count == CNT_W'(FIFO_DEPTH)));
        accept     = wr_pulse & rx_ready;
        drop       = wr_pulse & ~rx_ready;
        push       = accept && (word_cnt == 2'd3);
        pop        = bus.veri_ins_pop && (count != '0);
        push_entry = {bus.host_data, asm_reg};
    end

    // Host side: edge detector, word assembly, acknowledge and overflow flag.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            wr_req_d    <= 1'b1;
            word_cnt    <= 2'd0;
            asm_reg     <= '0;
            wr_ack      <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            wr_req_d <= bus.wr_req;
            if (accept) begin
                asm_reg  <= {bus.host_data, asm_reg[95:32]};
                word_cnt <= word_cnt + 2'd1;
            end
            if (accept) begin
                wr_ack <= 1'b1;
            end else if (!bus.wr_req) begin
                wr_ack <= 1'b0;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                rx_overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                rx_overflow <= 1'b0;
            end
        end
    end

    // Entry storage; contents need no reset since the pointers gate all reads.
    always_ff @(posedge clk_100M) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // FIFO pointers, occupancy and the registered pop output.
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_out     <= '0;
            data_out_vld <= 1'b0;
        end else begin
            data_out_vld <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                data_out <= mem[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Output drive.
    always_comb begin
        bus.wr_ack            = wr_ack;
        bus.rx_ready          = rx_ready;
        bus.rx_overflow       = rx_overflow;
        bus.veri_data_out     = data_out;
        bus.veri_data_out_vld = data_out_vld;
        bus.fifo_count        = count;
        bus.frame_busy        = (word_cnt != 2'd0);
    end
endmodule
